multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Iterative signed multiply/divide execution unit.
- Services the R-type MULT (ALU opcode field 6) and DIV (ALU opcode field 7) instructions, which the ALU control decoder diverts away from the single-cycle ALU.
- The execute stage issues one operation with a start pulse. The unit asserts busy so the pipeline stalls, then returns the result, an exception flag and the destination register tag with a one-cycle ready pulse for writeback.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CNTW, 6: iteration counter width; must hold the value WIDTH.

Ports:
- clock  input  1  single design clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
- ctrl_MULT  input  1  one-cycle start pulse for a signed multiply.
- ctrl_DIV  input  1  one-cycle start pulse for a signed divide.
- data_operandA  input  WIDTH  multiplicand or dividend; sampled with the start pulse.
- data_operandB  input  WIDTH  multiplier or divisor; sampled with the start pulse.
- rd_in  input  5  destination register tag; sampled with the start pulse.
- busy  output  1  high from the start-accept edge until the edge that raises data_resultRDY.
- data_result  output  WIDTH  product (low WIDTH bits) or truncated quotient.
- data_exception  output  1  overflow or divide-by-zero; valid while data_resultRDY is high.
- data_resultRDY  output  1  one-cycle completion pulse.
- rd_out  output  5  latched rd_in, valid while data_resultRDY is high.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy, data_resultRDY and data_exception = 0; data_result = 0; rd_out = 0; counter = 0.
  - Reset mid-operation aborts the operation; no ready pulse is produced.
- States: IDLE, MULT, DIV, DONE.
- IDLE:
  - On an edge with ctrl_MULT=1, latch the operands and rd_in, go to MULT, set busy=1, counter=0.
  - Else on an edge with ctrl_DIV=1, the same, but go to DIV.
  - ctrl_MULT has priority when both are high; that operation is a multiply.
- Start pulses arriving while not in IDLE are ignored. No queueing; the decoder/stall logic must not issue while busy.
- MULT:
  - Operate on operand magnitudes; radix-2 shift-add into a 2*WIDTH accumulator, one bit per cycle.
  - After WIDTH iterations (counter reaches WIDTH), negate the product if the operand signs differ, then go to DONE.
  - data_result = low WIDTH bits of the signed product.
  - data_exception = 1 iff the upper WIDTH+1 bits of the 2*WIDTH signed product are not all equal (result does not fit in WIDTH signed bits).
- DIV:
  - Operate on magnitudes; restoring division, one quotient bit per cycle, WIDTH iterations.
  - Quotient is negated if the operand signs differ. Rounding is truncation toward zero; the remainder is discarded.
  - Divisor = 0 (checked at the accept edge): skip iteration and go to DONE on the next edge; data_result=0, data_exception=1.
  - Dividend = -2^(WIDTH-1) with divisor = -1: data_result = 0x80000000 (for WIDTH=32), data_exception=1, full latency.
- DONE: lasts exactly one cycle.
  - data_resultRDY=1, rd_out valid, busy=0.
  - The next edge returns to IDLE and clears data_resultRDY.
  - data_result and data_exception hold their values until the next accepted start or reset.
  - A start pulse during DONE is ignored; the issuer waits for IDLE.
- Latency: start accepted at edge k; data_resultRDY is high in the cycle following edge k+WIDTH+1 (k+33 for WIDTH=32).
  - Divide-by-zero: data_resultRDY high in the cycle following edge k+1.
- busy is low in IDLE and DONE, and high in MULT and DIV.

Test Plan:
- Reset release, no starts for 50 cycles -> all outputs remain 0, busy=0, state IDLE.
- MULT A=7, B=-6, rd_in=5 -> busy high 33 cycles; ready pulse exactly 1 cycle, 33 cycles after accept; data_result=0xFFFFFFD6 (-42); exception=0; rd_out=5.
- MULT A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1. MULT A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF, exception=0.
- DIV A=-7, B=2 -> data_result=0xFFFFFFFD (-3), exception=0. DIV A=100, B=0 -> ready one cycle after accept, result 0, exception=1. DIV A=0x80000000, B=-1 -> 0x80000000, exception=1.
- ctrl_MULT and ctrl_DIV high together with A=3, B=4 -> result 12 (multiply). A second ctrl_DIV pulse at cycle 10 of the operation -> ignored; only one ready pulse.
- Reset asserted (reset=0) at cycle 15 of a MULT -> outputs clear immediately, no ready pulse. A new MULT after release completes normally with the correct product.

Source files
------------

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit. It uses a radix-2 shift-add multiply and a
// restoring divide, each taking one bit per cycle on operand magnitudes.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [4:0]       rd_out
);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t             state, state_next;
    logic [CNTW-1:0]    count;
    logic [2*WIDTH-1:0] acc;      // mult: {partial product, multiplier}; div: low half is quotient
    logic [WIDTH-1:0]   mcand;    // multiplicand or divisor magnitude
    logic [WIDTH:0]     rem;
    logic               neg;
    logic               div_zero;

    logic               start_mult, start_div, last;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic               mult_exc, div_exc;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign2(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (2*WIDTH)'(-v) : v;
    endfunction

    // The product overflows when its upper WIDTH+1 bits are not a pure sign extension.
    function automatic logic fits_signed(input logic [2*WIDTH-1:0] p);
        return (&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]);
    endfunction

    assign start_mult = (state == S_IDLE) && ctrl_MULT;
    assign start_div  = (state == S_IDLE) && !ctrl_MULT && ctrl_DIV;
    assign last       = (count == CNTW'(WIDTH));

    assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign shifted  = {rem[WIDTH-1:0], acc[WIDTH-1]};
    assign trial    = shifted - {1'b0, mcand};
    assign prod     = apply_sign2(acc, neg);
    assign quot     = neg ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign mult_exc = !fits_signed(prod);
    // Only -2^(WIDTH-1) / -1 leaves a positive quotient with its top bit set.
    assign div_exc  = !neg && acc[WIDTH-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_mult)     state_next = S_MULT;
                else if (start_div) state_next = S_DIV;
            end
            S_MULT:  if (last) state_next = S_DONE;
            S_DIV:   if (last || div_zero) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy           = (state == S_MULT) || (state == S_DIV);
    assign data_resultRDY = (state == S_DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count          <= '0;
            acc            <= '0;
            mcand          <= '0;
            rem            <= '0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            rd_out         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_mult || start_div) begin
                        count          <= '0;
                        rem            <= '0;
                        neg            <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        div_zero       <= (data_operandB == '0);
                        rd_out         <= rd_in;
                        data_result    <= '0;
                        data_exception <= 1'b0;
                        if (start_mult) begin
                            acc   <= {{WIDTH{1'b0}}, magnitude(data_operandB)};
                            mcand <= magnitude(data_operandA);
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, magnitude(data_operandA)};
                            mcand <= magnitude(data_operandB);
                        end
                    end
                end
                S_MULT: begin
                    if (last) begin
                        data_result    <= prod[WIDTH-1:0];
                        data_exception <= mult_exc;
                    end else begin
                        acc   <= {add_sum, acc[WIDTH-1:1]};
                        count <= count + 1'b1;
                    end
                end
                S_DIV: begin
                    if (div_zero) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
                    end else if (last) begin
                        data_result    <= quot;
                        data_exception <= div_exc;
                    end else begin
                        if (!trial[WIDTH]) begin
                            rem            <= trial;
                            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b1};
                        end else begin
                            rem            <= shifted;
                            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b0};
                        end
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: a vector table of operations plus the
// reset-idle, ignored-restart and mid-operation reset sequences.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [4:0]  rd_in = '0;
    logic        busy;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;

    multdiv_unit #(.WIDTH(32), .CNTW(6)) dut (
        .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB), .rd_in(rd_in),
        .busy(busy), .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .rd_out(rd_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        logic        exp_exc;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one start pulse, then measures latency, busy cycles, pulse width
    // and any extra ready pulses over the following 40 cycles.
    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic inject,
                          output logic [31:0] res, output logic exc, output logic [4:0] rdo,
                          output int lat, output int busy_cnt, output int width,
                          output int extra, output logic [31:0] held);
        int t;
        @(negedge clock);
        ctrl_MULT = m; ctrl_DIV = d;
        data_operandA = a; data_operandB = b; rd_in = rd;
        @(negedge clock);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0; rd_in = '0;
        t = 0; busy_cnt = 0;
        while (!data_resultRDY && t < 100) begin
            if (busy) busy_cnt++;
            if (inject && t == 10) ctrl_DIV = 1'b1;
            if (inject && t == 11) ctrl_DIV = 1'b0;
            @(negedge clock);
            t++;
        end
        ctrl_DIV = 1'b0;
        lat = (t >= 100) ? 999 : t;
        res = data_result; exc = data_exception; rdo = rd_out;
        width = 0;
        while (data_resultRDY && width < 10) begin
            width++;
            @(negedge clock);
        end
        extra = 0;
        repeat (40) begin
            if (data_resultRDY) extra++;
            @(negedge clock);
        end
        held = data_result;
    endtask

    initial begin
        logic [31:0] res, held;
        logic        exc;
        logic [4:0]  rdo;
        int lat, bc, w, extra, bad;

        vecs[0]  = '{1'b1, 1'b0, 32'd7,        32'hFFFF_FFFA, 5'd5,  32'hFFFF_FFD6, 1'b0, 33};
        vecs[1]  = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd1,  32'h0000_0000, 1'b1, 33};
        vecs[2]  = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1,        5'd2,  32'h7FFF_FFFF, 1'b0, 33};
        vecs[3]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,        5'd3,  32'hFFFF_FFFD, 1'b0, 33};
        vecs[4]  = '{1'b0, 1'b1, 32'd100,      32'd0,        5'd4,  32'h0000_0000, 1'b1, 1};
        vecs[5]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h8000_0000, 1'b1, 33};
        vecs[6]  = '{1'b1, 1'b1, 32'd3,        32'd4,        5'd7,  32'd12,        1'b0, 33};
        vecs[7]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'h0000_0000, 1'b1, 33};
        vecs[8]  = '{1'b0, 1'b1, 32'h8000_0000, 32'd1,        5'd9,  32'h8000_0000, 1'b0, 33};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 5'd10, 32'd25,        1'b0, 33};
        vecs[10] = '{1'b0, 1'b1, 32'd7,        32'hFFFF_FFF9, 5'd31, 32'hFFFF_FFFF, 1'b0, 33};

        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clock);
            if (busy !== 1'b0 || data_resultRDY !== 1'b0 || data_exception !== 1'b0 ||
                data_result !== 32'd0 || rd_out !== 5'd0) bad++;
        end
        check("idle_after_reset", bad, 0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b0,
                   res, exc, rdo, lat, bc, w, extra, held);
            check($sformatf("v%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("v%0d_exc", i), {31'd0, exc}, {31'd0, vecs[i].exp_exc});
            check($sformatf("v%0d_rd", i), {27'd0, rdo}, {27'd0, vecs[i].rd});
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_lat);
            check($sformatf("v%0d_pulse_width", i), w, 1);
            check($sformatf("v%0d_extra_pulses", i), extra, 0);
            check($sformatf("v%0d_result_held", i), held, vecs[i].exp_res);
        end

        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 5'd12, 1'b1, res, exc, rdo, lat, bc, w, extra, held);
        check("inject_result", res, 32'hFFFF_FFD6);
        check("inject_latency", lat, 33);
        check("inject_extra_pulses", extra, 0);

        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = 32'd9; data_operandB = 32'd9; rd_in = 5'd21;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (15) @(negedge clock);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("abort_result", data_result, 32'd0);
        check("abort_rd", {27'd0, rd_out}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("abort_no_pulse", bad, 0);

        run_op(1'b1, 1'b0, 32'd123, 32'hFFFF_FFFE, 5'd17, 1'b0, res, exc, rdo, lat, bc, w, extra, held);
        check("post_reset_result", res, 32'hFFFF_FF0A);
        check("post_reset_exc", {31'd0, exc}, 32'd0);
        check("post_reset_rd", {27'd0, rdo}, 32'd17);
        check("post_reset_latency", lat, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
